// File: rtl/vjtag_loader_pkg.sv
// Shared types and helpers for the virtual-JTAG memory loader back end.
package vjtag_loader_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_t;

    // Byte-lane count for the default 16-bit loader word; the top derives its own from DATA_W.
    localparam int DATA_W_DEFAULT = 16;
    localparam int BE_W           = DATA_W_DEFAULT / 8;

    // Ceiling log2, elaboration-time helper for port and register widths.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Byte enables covering the first nbits bits of a word (LSB lane first, up to 8 lanes).
    function automatic logic [7:0] be_from_bits(input int nbits);
        logic [7:0] m;
        int         nbytes;
        m      = '0;
        nbytes = (nbits + 7) / 8;
        for (int b = 0; b < 8; b++) begin
            if (b < nbytes) begin
                m[b] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head; push on full and pop on empty are ignored.
module sync_fifo
    import vjtag_loader_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DEPTH = 16
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    push,
    input  logic [WIDTH-1:0]        din,
    input  logic                    pop,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   count
);

    localparam int PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage write; only the pointers need clearing.
    // NOTE: the storage array is deliberately left out of reset -- count gates every read, so stale contents are never visible.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vjtag_stream_mm_writer.sv
// Assembles an LSB-first bit stream into words, buffers them, and writes them to a circular Avalon-MM window.
module vjtag_stream_mm_writer
    import vjtag_loader_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 25,
    parameter int FIFO_DEPTH = 16,
    parameter int BASE_ADDR  = 0,
    parameter int WORDS_MAX  = 512
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic                      Bit_Valid,
    input  logic                      Bit_Data,
    input  logic                      Frame_End,
    output logic                      Avalon_ChipEnable,
    output logic [ADDR_W-1:0]         Avalon_Address,
    output logic [DATA_W/8-1:0]       Avalon_ByteEnable,
    output logic [DATA_W-1:0]         Avalon_WriteData,
    output logic                      Avalon_Write,
    input  logic                      Avalon_WaitRequest,
    output logic                      Busy,
    output logic [clog2(WORDS_MAX):0] Words_Written,
    output logic                      Overflow,
    output logic                      Wrapped
);

    localparam int BYTES  = DATA_W / 8;
    localparam int IDX_W  = (clog2(WORDS_MAX) < 1) ? 1 : clog2(WORDS_MAX);
    localparam int CNT_W  = clog2(DATA_W);
    localparam int FIFO_W = DATA_W + BYTES;

    wr_state_t                  state, state_n;
    logic [DATA_W-1:0]          asm_data, asm_next;
    logic [CNT_W-1:0]           cnt;
    logic [IDX_W-1:0]           index;
    logic                       start_pending;
    logic                       accept, bit_in, full_push, flush_push, push_req;
    logic [BYTES-1:0]           push_be;
    logic                       done, clear_all, fifo_pop, load;
    logic [FIFO_W-1:0]          fifo_dout;
    logic                       fifo_full, fifo_empty;
    logic [clog2(FIFO_DEPTH):0] fifo_count;
    int                         cnt_after;

    assign Avalon_ChipEnable = 1'b1;
    assign Avalon_Write      = (state == ST_WRITE);
    assign Avalon_Address    = ADDR_W'(BASE_ADDR) + ADDR_W'(index);
    assign Busy              = Avalon_Write || (fifo_count != '0) || (cnt != '0);

    // A transfer completes on any edge where the request is up and the slave is not stalling.
    assign done      = (state == ST_WRITE) && !Avalon_WaitRequest;
    // Start restarts at once when idle; during a write it waits for the completing edge.
    assign clear_all = (Start && (state == ST_IDLE)) || (done && (start_pending || Start));

    // Incoming bits are ignored while a restart is outstanding.
    assign accept     = !start_pending && !Start;
    assign bit_in     = Bit_Valid && accept;
    assign cnt_after  = int'(cnt) + (bit_in ? 1 : 0);
    assign full_push  = bit_in && (cnt == CNT_W'(DATA_W - 1));
    assign flush_push = Frame_End && accept && !full_push && (cnt_after > 0);
    assign push_req   = full_push || flush_push;
    assign push_be    = full_push ? '1 : BYTES'(be_from_bits(cnt_after));

    // Place the incoming bit at its position so a flush leaves the unreceived bits at zero.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        asm_next = asm_data;
        if (bit_in) begin
            asm_next[cnt] = Bit_Data;
        end
    end

    // Assembler register: cleared after every push, full or partial.
    always_ff @(posedge Clk) begin
        if (Reset || clear_all || push_req) begin
            asm_data <= '0;
            cnt      <= '0;
        end else if (bit_in) begin
            asm_data <= asm_next;
            cnt      <= cnt + 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk   (Clk),
        .Reset (Reset || clear_all),
        .push  (push_req),
        .din   ({push_be, asm_next}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Master FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    // Next state and pop decision; a completing write can pop the next word on the same edge.
    always_comb begin
        state_n  = state;
        fifo_pop = 1'b0;
        load     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!clear_all && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    load     = 1'b1;
                    state_n  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (done) begin
                    if (clear_all) begin
                        state_n = ST_IDLE;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        load     = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Write payload, window index, completion counter and sticky status.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Avalon_WriteData  <= '0;
            Avalon_ByteEnable <= '0;
            index             <= '0;
            Words_Written     <= '0;
            Overflow          <= 1'b0;
            Wrapped           <= 1'b0;
            start_pending     <= 1'b0;
        end else begin
            if (load) begin
                Avalon_WriteData  <= fifo_dout[DATA_W-1:0];
                Avalon_ByteEnable <= fifo_dout[FIFO_W-1:DATA_W];
            end
            if (clear_all) begin
                index         <= '0;
                Words_Written <= '0;
                Overflow      <= 1'b0;
                Wrapped       <= 1'b0;
                start_pending <= 1'b0;
            end else begin
                if ((state == ST_WRITE) && Start) start_pending <= 1'b1;
                if (push_req && fifo_full)        Overflow      <= 1'b1;
                if (done) begin
                    if (index == IDX_W'(WORDS_MAX - 1)) begin
                        index   <= '0;
                        Wrapped <= 1'b1;
                    end else begin
                        index <= index + 1'b1;
                    end
                    if (Words_Written != '1) Words_Written <= Words_Written + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vjtag_stream_mm_writer.sv
// Directed bench for the stream-to-Avalon writer: small FIFO and window to reach overflow and wrap quickly.
module tb_vjtag_stream_mm_writer;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 25;
    localparam int BASE   = 'h100;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0, bit_valid = 1'b0, bit_data = 1'b0, frame_end = 1'b0;
    logic              wait_req = 1'b0;
    logic              chip_en, av_write, busy, overflow, wrapped;
    logic [ADDR_W-1:0] av_addr;
    logic [1:0]        av_be;
    logic [DATA_W-1:0] av_data;
    logic [2:0]        words_written;

    typedef struct {
        int addr;
        int data;
        int be;
        int cyc;
    } wr_rec_t;

    wr_rec_t q[$];
    int      cyc = 0;
    int      n_checks = 0;
    int      n_errors = 0;
    int      idle_cyc = 0;

    vjtag_stream_mm_writer #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (2),
        .BASE_ADDR  (BASE),
        .WORDS_MAX  (4)
    ) dut (
        .Clk                (clk),
        .Reset              (rst),
        .Start              (start),
        .Bit_Valid          (bit_valid),
        .Bit_Data           (bit_data),
        .Frame_End          (frame_end),
        .Avalon_ChipEnable  (chip_en),
        .Avalon_Address     (av_addr),
        .Avalon_ByteEnable  (av_be),
        .Avalon_WriteData   (av_data),
        .Avalon_Write       (av_write),
        .Avalon_WaitRequest (wait_req),
        .Busy               (busy),
        .Words_Written      (words_written),
        .Overflow           (overflow),
        .Wrapped            (wrapped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change 2 ns after the rising edge, so the falling edge sees settled handshakes.
    always @(negedge clk) begin
        if (!rst && av_write && !wait_req) begin
            q.push_back('{addr: int'(av_addr), data: int'(av_data), be: int'(av_be), cyc: cyc});
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_frame_end();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] w, input int n, input bit fe_last);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b1;
            bit_data  = w[i];
            frame_end = fe_last && (i == n - 1);
            tick();
        end
        bit_valid = 1'b0;
        bit_data  = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        idle_cyc = cyc;
        check(tag, busy, 0);
    endtask

    task automatic wait_write(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!av_write && n < 50);
        check(tag, av_write, 1);
    endtask

    task automatic check_wr(input string tag, input int idx, input int addr, input int data, input int be);
        if (idx < q.size()) begin
            check({tag, "_addr"}, q[idx].addr, addr);
            check({tag, "_data"}, q[idx].data, data);
            check({tag, "_be"},   q[idx].be,   be);
        end else begin
            check({tag, "_present"}, q.size(), idx + 1);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_write", av_write, 0);
        check("rst_addr", av_addr, BASE);
        check("rst_be", av_be, 0);
        check("rst_data", av_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ww", words_written, 0);
        check("rst_ovf", overflow, 0);
        check("rst_wrap", wrapped, 0);
        check("rst_ce", chip_en, 1);
        rst = 1'b0;
        tick();

        // Two full words, stalled then released for back-to-back writes
        pulse_start();
        q.delete();
        wait_req = 1'b1;
        send_bits(16'hBEEF, 16, 1'b0);
        send_bits(16'h1234, 16, 1'b0);
        wait_req = 1'b0;
        wait_idle("t1_idle");
        check("t1_count", q.size(), 2);
        check_wr("t1_w0", 0, BASE, 'hBEEF, 3);
        check_wr("t1_w1", 1, BASE + 1, 'h1234, 3);
        if (q.size() == 2) begin
            check("t1_b2b", q[1].cyc, q[0].cyc + 1);
            check("t1_busy_fall", idle_cyc, q[1].cyc + 1);
        end
        check("t1_ww", words_written, 2);

        // Partial words: 5 bits + separate Frame_End, 12 bits with Frame_End on the last bit
        pulse_start();
        q.delete();
        send_bits(16'h001D, 5, 1'b0);
        pulse_frame_end();
        wait_idle("t2_idle_a");
        send_bits(16'h0ABC, 12, 1'b1);
        wait_idle("t2_idle_b");
        check("t2_count", q.size(), 2);
        check_wr("t2_w0", 0, BASE, 'h001D, 1);
        check_wr("t2_w1", 1, BASE + 1, 'h0ABC, 3);
        check("t2_ww", words_written, 2);

        // Stall for 7 cycles: payload held, one index step after release
        pulse_start();
        q.delete();
        wait_req = 1'b1;
        send_bits(16'hC3A5, 16, 1'b0);
        @(negedge clk);
        check("t3_lat_k", av_write, 0);
        tick();
        @(negedge clk);
        check("t3_lat_k1", av_write, 1);
        for (int i = 0; i < 7; i++) begin
            check("t3_hold", {av_addr, av_data, av_be}, {25'(BASE), 16'hC3A5, 2'b11});
            tick();
            @(negedge clk);
        end
        wait_req = 1'b0;
        wait_idle("t3_idle_a");
        check("t3_ww", words_written, 1);
        send_bits(16'h0F0F, 16, 1'b0);
        wait_idle("t3_idle_b");
        check("t3_count", q.size(), 2);
        check_wr("t3_w0", 0, BASE, 'hC3A5, 3);
        check_wr("t3_w1", 1, BASE + 1, 'h0F0F, 3);

        // Window wrap after four words; full word with Frame_End pushes once; lone Frame_End does nothing
        pulse_start();
        q.delete();
        for (int i = 0; i < 6; i++) begin
            send_bits(16'hA001 + 16'(i), 16, i == 5);
            wait_idle("t4_idle");
            if (i == 2) check("t4_nowrap", wrapped, 0);
            if (i == 3) check("t4_wrap", wrapped, 1);
        end
        pulse_frame_end();
        repeat (3) tick();
        @(negedge clk);
        check("t4_count", q.size(), 6);
        check_wr("t4_w3", 3, BASE + 3, 'hA004, 3);
        check_wr("t4_w4", 4, BASE, 'hA005, 3);
        check_wr("t4_w5", 5, BASE + 1, 'hA006, 3);
        check("t4_ww", words_written, 6);
        check("t4_busy", busy, 0);

        // Overflow: one in flight, two buffered, fourth dropped
        pulse_start();
        q.delete();
        check("t5_wrap_clr", wrapped, 0);
        wait_req = 1'b1;
        for (int i = 0; i < 4; i++) send_bits(16'hB001 + 16'(i), 16, 1'b0);
        @(negedge clk);
        check("t5_ovf", overflow, 1);
        wait_req = 1'b0;
        wait_idle("t5_idle");
        check("t5_count", q.size(), 3);
        check_wr("t5_w0", 0, BASE, 'hB001, 3);
        check_wr("t5_w2", 2, BASE + 2, 'hB003, 3);
        check("t5_ww", words_written, 3);
        check("t5_ovf_sticky", overflow, 1);

        // Start during a stalled write: write finishes uncounted, pending bits ignored
        pulse_start();
        q.delete();
        check("t6_ovf_clr", overflow, 0);
        wait_req = 1'b1;
        send_bits(16'h1111, 16, 1'b0);
        wait_write("t6_write_seen");
        pulse_start();
        send_bits(16'h2222, 16, 1'b1);
        wait_req = 1'b0;
        wait_idle("t6_idle_a");
        check("t6_ww_zero", words_written, 0);
        check("t6_count_a", q.size(), 1);
        check_wr("t6_w0", 0, BASE, 'h1111, 3);
        send_bits(16'h3333, 16, 1'b0);
        wait_idle("t6_idle_b");
        check("t6_count_b", q.size(), 2);
        check_wr("t6_w1", 1, BASE, 'h3333, 3);
        check("t6_ww_one", words_written, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vjtag_stream_mm_writer.md
Name: vjtag_stream_mm_writer

Overview:
Clk-domain back end of the virtual-JTAG memory loader. It assembles an already-synchronised LSB-first bit stream into DATA_W words and buffers them in a small FIFO. It drains the FIFO into Avalon-MM as single-word writes to a circular window starting at BASE_ADDR. It generalises the fixed 16-bit, 512-word loader with parametrised width, depth and window size, partial-word flush with byte enables, and overflow/wrap status.

Parameters:
DATA_W, 16, word width in bits; multiple of 8, range 8..64
ADDR_W, 25, Avalon word-address width
FIFO_DEPTH, 16, word FIFO depth; power of 2, at least 2
BASE_ADDR, 0, first Avalon word address of the window
WORDS_MAX, 512, window length in words; address index wraps after WORDS_MAX-1

Ports:
Clk  in  1  system clock; all logic rising-edge
Reset  in  1  synchronous, active-high
Start  in  1  pulse; begins a new load (clears index, counters, sticky flags, pending bits)
Bit_Valid  in  1  Bit_Data is valid this cycle
Bit_Data  in  1  serial data, LSB of each word first
Frame_End  in  1  pulse; flush the partially assembled word
Avalon_ChipEnable  out  1  constant 1
Avalon_Address  out  ADDR_W  BASE_ADDR + index
Avalon_ByteEnable  out  DATA_W/8  per-byte write enable
Avalon_WriteData  out  DATA_W  write data
Avalon_Write  out  1  write request
Avalon_WaitRequest  in  1  slave stall
Busy  out  1  Avalon_Write | FIFO non-empty | assembler holds bits
Words_Written  out  clog2(WORDS_MAX)+1  completed writes since Start; saturates at all-ones
Overflow  out  1  sticky; a word was dropped because the FIFO was full
Wrapped  out  1  sticky; index wrapped to 0 at least once

Behaviour:
- Reset clears all state. Outputs after Reset: Avalon_Write=0, Address=BASE_ADDR, ByteEnable=0, WriteData=0, Busy=0, Words_Written=0, Overflow=0, Wrapped=0. Avalon_ChipEnable stays 1.
- Assembler: shift register plus bit counter 0..DATA_W-1. Each Bit_Valid places Bit_Data at position cnt.
  - If the bit completes the word (cnt==DATA_W-1), the word is pushed with all ByteEnable bits set, and cnt returns to 0.
- Frame_End with cnt>0: push the partial word. Unreceived bits are 0. ByteEnable bit b is 1 iff byte b holds at least one received bit. cnt returns to 0.
  - Frame_End with cnt==0: no action.
  - Bit_Valid and Frame_End in the same cycle: the bit is included first. If that bit completes the word, exactly one full word is pushed and no empty word follows.
- FIFO full at push time: the word is dropped, Overflow is set, and the assembler still clears. A simultaneous pop frees no slot for that push (push is checked against pre-edge full).
- Avalon master FSM states: IDLE and WRITE.
  - IDLE, FIFO non-empty: pop the head into registered WriteData/ByteEnable, go to WRITE, Avalon_Write=1.
  - WRITE: Address, WriteData and ByteEnable are held stable while WaitRequest=1.
  - WRITE, WaitRequest=0 at an edge: the transfer completes. index advances (WORDS_MAX-1 -> 0 sets Wrapped) and Words_Written increments.
    - If the FIFO is non-empty, pop the next word on the same edge and stay in WRITE. This gives back-to-back writes.
    - Otherwise go to IDLE.
- Latency: a word completed at edge k is in the FIFO after k. With the FIFO empty and the FSM idle, Avalon_Write is high after edge k+1.
- Start while FSM is in IDLE: index=0 and the FIFO, assembler, counters and flags are all cleared on that edge.
- Start while FSM is in WRITE: the current transfer is never aborted.
  - start_pending is set, and Bit_Valid/Frame_End are ignored while it is pending.
  - On the completing edge, the normal clear is applied instead of advancing or popping. The completed write is not counted.
- Reset mid-transfer drops Avalon_Write immediately. Slaves on this bus tolerate this.

Decomposition:
- Package vjtag_loader_pkg holds:
  - the FSM state enum (ST_IDLE, ST_WRITE)
  - a clog2 function
  - a byte-enable-from-bit-count function
  - a localparam BE_W = DATA_W/8
- Sub-module sync_fifo holds the registered-output-free FIFO.
  - Parameters: WIDTH = DATA_W+BE_W, DEPTH.
  - Interface: push, pop, full, empty, count.
  - Pop on empty and push on full are ignored.
  - Reset is synchronous and active-high.

Test Plan:
- DATA_W=16: 32 bits encoding 0xBEEF then 0x1234 (LSB first), WaitRequest=0 -> writes 0xBEEF@BASE, 0x1234@BASE+1, BE=2'b11, back-to-back; Words_Written=2; Busy falls 1 cycle after the last handshake.
- 5 bits 1,0,1,1,1 then Frame_End -> one write of 0x001D with BE=2'b01; 12 bits then Frame_End -> BE=2'b11, upper 4 bits 0.
- WaitRequest held 1 for 7 cycles during a write -> Address/Data/BE unchanged for all 7 cycles; exactly one index increment after release.
- WORDS_MAX=4, 6 words -> addresses BASE+0..3, then BASE+0, BASE+1; Wrapped=1 after the 4th completion.
- FIFO_DEPTH=2, WaitRequest=1, 4 words streamed -> 1 word in flight, 2 buffered, 1 dropped; Overflow=1; after release exactly 3 writes.
- Start during a stalled write, then new bits -> stalled write completes uncounted; bits sent while pending are ignored; next write goes to BASE with Words_Written restarting at 1.
